rvv_backend_uop_queue: RTL and testbench

Uops Queue between the decode unit and dispatch. Circular buffer that accepts up to `NUM_DE_UOP` decoded uops per cycle and presents up to `NUM_DP_UOP` of the oldest uops per cycle to dispatch, strictly in order. It is the receiving end of the decoder's `uop_valid_de2uq`/`uop_de2uq` interface. It supplies the free-space indication the decode control path uses to gate instruction issue.

---
 rtl/rvv_backend_uop_queue_pkg.sv | 42 ++++
 rtl/rvv_backend_uq_buffer.sv | 42 ++++
 rtl/rvv_backend_uop_queue.sv | 141 ++++++++++++++
 tb/tb_rvv_backend_uop_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rvv_backend_uop_queue_pkg.sv
// ============================================================================
// Module   : rvv_backend_uop_queue_pkg
// Purpose  : Shared uop type, port counts and helpers for the uop queue.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rvv_backend_uop_queue_pkg;

  localparam int NUM_DE_UOP = 4;
  localparam int NUM_DP_UOP = 2;
  localparam int UQ_DEPTH   = 16;

  typedef struct packed {
    logic [31:0] uop_pc;
    logic [2:0]  uop_funct3;
    logic [5:0]  uop_funct6;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [4:0]  vd;
    logic [2:0]  uop_index;
    logic        last_uop_valid;
  } UOP_QUEUE_t;

  // Number of consecutive ones starting at bit 0; callers zero-extend narrower masks.
  function automatic int unsigned lead_ones(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (!v[i]) return cnt;
      cnt++;
    end
    return cnt;
  endfunction

  function automatic logic is_thermo(input logic [31:0] v);
    return ((v & (v + 32'd1)) == 32'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rvv_backend_uq_buffer.sv
// ============================================================================
// Module   : rvv_backend_uq_buffer
// Purpose  : Uop storage, NUM_WR write ports and NUM_RD combinational read
//            ports addressed as base pointer + port offset, modulo DEPTH.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rvv_backend_uq_buffer
  import rvv_backend_uop_queue_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NUM_WR = 4,
  parameter int NUM_RD = 2,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [PTR_W-1:0]  wr_base,
  input  logic [NUM_WR-1:0] wr_en,
  input  UOP_QUEUE_t        wr_data [NUM_WR-1:0],
  input  logic [PTR_W-1:0]  rd_base,
  output UOP_QUEUE_t        rd_data [NUM_RD-1:0]
);

  UOP_QUEUE_t r_mem [DEPTH];

  // Entries carry no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i]) r_mem[wr_base + PTR_W'(i)] <= wr_data[i];
    end
  end

  generate
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      assign rd_data[j] = r_mem[rd_base + PTR_W'(j)];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rvv_backend_uop_queue.sv
// ============================================================================
// Module   : rvv_backend_uop_queue
// Purpose  : In-order circular uop queue between decode and dispatch.
//            Optional flush port via RVV_UQ_FLUSH_EN; checks via ASSERT_ON.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rvv_backend_uop_queue
  import rvv_backend_uop_queue_pkg::*;
#(
  parameter int UQ_DEPTH   = rvv_backend_uop_queue_pkg::UQ_DEPTH,
  parameter int NUM_DE_UOP = rvv_backend_uop_queue_pkg::NUM_DE_UOP,
  parameter int NUM_DP_UOP = rvv_backend_uop_queue_pkg::NUM_DP_UOP
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef RVV_UQ_FLUSH_EN
  input  logic                        trap_flush_rvv,
`endif
  input  logic [NUM_DE_UOP-1:0]       uop_valid_de2uq,
  input  UOP_QUEUE_t                  uop_de2uq [NUM_DE_UOP-1:0],
  output logic [NUM_DE_UOP-1:0]       uop_ready_uq2de,
  output logic [NUM_DP_UOP-1:0]       uop_valid_uq2dp,
  output UOP_QUEUE_t                  uop_uq2dp [NUM_DP_UOP-1:0],
  input  logic [NUM_DP_UOP-1:0]       uop_ready_dp2uq,
  output logic [$clog2(UQ_DEPTH):0]   uq_count
);

  localparam int c_ptr_w = $clog2(UQ_DEPTH);
  localparam int c_cnt_w = $clog2(UQ_DEPTH) + 1;

  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic [c_cnt_w-1:0]    w_free;
  logic [c_cnt_w-1:0]    w_push_cnt;
  logic [c_cnt_w-1:0]    w_push_acc;
  logic [c_cnt_w-1:0]    w_pop_cnt;
  logic                  w_flush;
  logic                  w_push_ok;
  logic [NUM_DP_UOP-1:0] w_valid;
  logic [NUM_DE_UOP-1:0] w_wr_en;
  UOP_QUEUE_t            w_rd_data [NUM_DP_UOP-1:0];

`ifdef RVV_UQ_FLUSH_EN
  assign w_flush = trap_flush_rvv;
`else
  assign w_flush = 1'b0;
`endif

  // Handshake masks depend on the registered count only (plus the flush gate).
  assign w_free = c_cnt_w'(UQ_DEPTH) - r_count;

  always_comb begin
    uop_ready_uq2de = '0;
    for (int i = 0; i < NUM_DE_UOP; i++) begin
      uop_ready_uq2de[i] = (w_free > c_cnt_w'(i));
    end
  end

  always_comb begin
    w_valid = '0;
    for (int j = 0; j < NUM_DP_UOP; j++) begin
      w_valid[j] = (r_count > c_cnt_w'(j)) && !w_flush;
    end
  end

  assign uop_valid_uq2dp = w_valid;
  assign uq_count        = r_count;

  // All-or-nothing push: the whole thermometer run must fit in free space.
  assign w_push_cnt = c_cnt_w'(lead_ones(32'(uop_valid_de2uq)));
  assign w_push_ok  = !w_flush && (w_push_cnt <= w_free);
  assign w_push_acc = w_push_ok ? w_push_cnt : '0;
  assign w_pop_cnt  = c_cnt_w'(lead_ones(32'(uop_ready_dp2uq & w_valid)));

  always_comb begin
    w_wr_en = '0;
    for (int i = 0; i < NUM_DE_UOP; i++) begin
      w_wr_en[i] = w_push_ok && (c_cnt_w'(i) < w_push_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_push_acc[c_ptr_w-1:0];
      r_rd_ptr <= r_rd_ptr + w_pop_cnt[c_ptr_w-1:0];
      r_count  <= r_count + w_push_acc - w_pop_cnt;
    end
  end

  rvv_backend_uq_buffer #(
    .DEPTH  (UQ_DEPTH),
    .NUM_WR (NUM_DE_UOP),
    .NUM_RD (NUM_DP_UOP),
    .PTR_W  (c_ptr_w)
  ) u_buffer (
    .clk     (clk),
    .wr_base (r_wr_ptr),
    .wr_en   (w_wr_en),
    .wr_data (uop_de2uq),
    .rd_base (r_rd_ptr),
    .rd_data (w_rd_data)
  );

  generate
    for (genvar j = 0; j < NUM_DP_UOP; j++) begin : g_out
      assign uop_uq2dp[j] = w_valid[j] ? w_rd_data[j] : '0;
    end
  endgenerate

`ifdef ASSERT_ON
  a_de_thermo: assert property (@(posedge clk) disable iff (!rst_n)
    is_thermo(32'(uop_valid_de2uq)))
    else $error("uop_valid_de2uq is not a thermometer mask");

  a_dp_thermo: assert property (@(posedge clk) disable iff (!rst_n)
    is_thermo(32'(uop_ready_dp2uq)))
    else $error("uop_ready_dp2uq is not a thermometer mask");

  a_push_drop: assert property (@(posedge clk) disable iff (!rst_n)
    w_flush || (w_push_cnt <= w_free))
    else $error("uop push dropped: queue lacks free entries");

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= c_cnt_w'(UQ_DEPTH))
    else $error("uop queue count exceeds depth");
`endif

endmodule

`default_nettype wire

// File: tb/tb_rvv_backend_uop_queue.sv
// ============================================================================
// Module   : tb_rvv_backend_uop_queue
// Purpose  : Directed self-checking bench for rvv_backend_uop_queue
//            (covers the flush port when RVV_UQ_FLUSH_EN is defined).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rvv_backend_uop_queue;
  import rvv_backend_uop_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] uop_valid_de2uq;
  UOP_QUEUE_t uop_de2uq [3:0];
  logic [3:0] uop_ready_uq2de;
  logic [1:0] uop_valid_uq2dp;
  UOP_QUEUE_t uop_uq2dp [1:0];
  logic [1:0] uop_ready_dp2uq;
  logic [4:0] uq_count;
`ifdef RVV_UQ_FLUSH_EN
  logic       trap_flush_rvv = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int next_tag = 0;
  int q[$];

  always #5 clk = ~clk;

  rvv_backend_uop_queue dut (
    .clk             (clk),
    .rst_n           (rst_n),
`ifdef RVV_UQ_FLUSH_EN
    .trap_flush_rvv  (trap_flush_rvv),
`endif
    .uop_valid_de2uq (uop_valid_de2uq),
    .uop_de2uq       (uop_de2uq),
    .uop_ready_uq2de (uop_ready_uq2de),
    .uop_valid_uq2dp (uop_valid_uq2dp),
    .uop_uq2dp       (uop_uq2dp),
    .uop_ready_dp2uq (uop_ready_dp2uq),
    .uq_count        (uq_count)
  );

  function automatic UOP_QUEUE_t mk(input int t);
    UOP_QUEUE_t u;
    u                = '0;
    u.uop_pc         = 32'h8000_0000 + 32'(t) * 4;
    u.uop_funct6     = t[5:0];
    u.vd             = t[4:0];
    u.vs2            = ~t[4:0];
    u.uop_index      = t[2:0];
    u.last_uop_valid = t[0];
    return u;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle of push mask `de` and pop mask `dp`, checked against the scoreboard.
  task automatic step(input logic [3:0] de, input logic [1:0] dp);
    int k, p, occ;
    logic [3:0] exp_r;
    logic [1:0] exp_v;
    logic ok;
    for (int i = 0; i < 4; i++) uop_de2uq[i] = mk(next_tag + i);
    uop_valid_de2uq = de;
    uop_ready_dp2uq = dp;
    #1;
    occ = q.size();
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (!de[i]) break;
      k++;
    end
    for (int i = 0; i < 4; i++) exp_r[i] = (16 - occ) >= (i + 1);
    for (int j = 0; j < 2; j++) exp_v[j] = occ >= (j + 1);
    check("ready_uq2de", 64'(uop_ready_uq2de), 64'(exp_r));
    check("valid_uq2dp", 64'(uop_valid_uq2dp), 64'(exp_v));
    p = 0;
    for (int j = 0; j < 2; j++) if (dp[j] && exp_v[j] && p == j) p++;
    for (int j = 0; j < p; j++) check($sformatf("head%0d", j), 64'(uop_uq2dp[j]), 64'(mk(q[j])));
    ok = (k <= 16 - occ);
    @(posedge clk);
    #1;
    for (int j = 0; j < p; j++) void'(q.pop_front());
    if (ok) for (int i = 0; i < k; i++) q.push_back(next_tag + i);
    next_tag += 4;
    uop_valid_de2uq = '0;
    uop_ready_dp2uq = '0;
    check("uq_count", 64'(uq_count), 64'(q.size()));
  endtask

  initial begin
    uop_valid_de2uq = '0;
    uop_ready_dp2uq = '0;
    for (int i = 0; i < 4; i++) uop_de2uq[i] = '0;

    #12;
    check("rst_valid", 64'(uop_valid_uq2dp), 64'h0);
    check("rst_ready", 64'(uop_ready_uq2de), 64'hF);
    check("rst_count", 64'(uq_count), 64'h0);
    check("rst_head0", 64'(uop_uq2dp[0]), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // A,B,C then read back; the push is not visible before the edge.
    step(4'b0111, 2'b00);
    check("abc_valid", 64'(uop_valid_uq2dp), 64'h3);
    check("abc_head0", 64'(uop_uq2dp[0]), 64'(mk(0)));
    check("abc_head1", 64'(uop_uq2dp[1]), 64'(mk(1)));
    check("abc_count", 64'(uq_count), 64'd3);
    check("abc_ready", 64'(uop_ready_uq2de), 64'hF);
    step(4'b0000, 2'b11);
    step(4'b0000, 2'b01);
    check("empty_valid", 64'(uop_valid_uq2dp), 64'h0);

    // Fill to 12, then push 4 / pop 2 together.
    step(4'b1111, 2'b00);
    step(4'b1111, 2'b00);
    step(4'b1111, 2'b00);
    step(4'b1111, 2'b11);
    check("pp_count14", 64'(uq_count), 64'd14);

    // Oversized push is dropped whole; a fitting one is accepted.
    check("near_full_ready", 64'(uop_ready_uq2de), 64'h3);
    step(4'b1111, 2'b00);
    check("drop_count", 64'(uq_count), 64'd14);
    step(4'b0011, 2'b00);
    check("full_count", 64'(uq_count), 64'd16);
    check("full_ready", 64'(uop_ready_uq2de), 64'h0);
    check("full_valid", 64'(uop_valid_uq2dp), 64'h3);
    for (int c = 0; c < 8; c++) step(4'b0000, 2'b11);
    check("drained_count", 64'(uq_count), 64'd0);

    // Move both pointers to 14, then push/pop across the wrap point.
    step(4'b1111, 2'b00);
    step(4'b1111, 2'b00);
    step(4'b0001, 2'b00);
    for (int c = 0; c < 4; c++) step(4'b0000, 2'b11);
    step(4'b0000, 2'b01);
    check("at14_rd_ptr", 64'(dut.r_rd_ptr), 64'd14);
    step(4'b1111, 2'b00);
    step(4'b0000, 2'b11);
    step(4'b0000, 2'b11);
    check("wrap_rd_ptr", 64'(dut.r_rd_ptr), 64'd2);

    // Asynchronous reset in the middle of a cycle.
    step(4'b1111, 2'b00);
    step(4'b1111, 2'b00);
    step(4'b0011, 2'b00);
    check("pre_rst_count", 64'(uq_count), 64'd10);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(uop_valid_uq2dp), 64'h0);
    check("arst_ready", 64'(uop_ready_uq2de), 64'hF);
    check("arst_count", 64'(uq_count), 64'h0);
    #1;
    rst_n = 1'b1;
    q.delete();
    @(posedge clk);
    #1;

`ifdef RVV_UQ_FLUSH_EN
    step(4'b1111, 2'b00);
    step(4'b0111, 2'b00);
    check("pre_flush_count", 64'(uq_count), 64'd7);
    trap_flush_rvv = 1'b1;
    for (int i = 0; i < 4; i++) uop_de2uq[i] = mk(100 + i);
    uop_valid_de2uq = 4'b1111;
    uop_ready_dp2uq = 2'b11;
    #1;
    check("flush_valid", 64'(uop_valid_uq2dp), 64'h0);
    @(posedge clk);
    #1;
    trap_flush_rvv  = 1'b0;
    uop_valid_de2uq = '0;
    uop_ready_dp2uq = '0;
    #1;
    check("flush_count", 64'(uq_count), 64'h0);
    check("flush_valid_after", 64'(uop_valid_uq2dp), 64'h0);
    check("flush_rd_ptr", 64'(dut.r_rd_ptr), 64'h0);
    q.delete();
    @(posedge clk);
    #1;
`endif

    // Queue still works after reset/flush.
    step(4'b0011, 2'b00);
    check("post_head0", 64'(uop_uq2dp[0]), 64'(mk(next_tag - 4)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
